// File: rtl/regfile_pkg.sv
// Shared constants, index/record types and capture-FSM state encoding
// for the decode-stage register file.
package regfile_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int NUM_REGS_DEF = 32;
    localparam int ADDR_W_DEF   = $clog2(NUM_REGS_DEF);

    typedef logic [ADDR_W_DEF-1:0] reg_idx_t;

    typedef struct packed {
        logic [DATA_W_DEF-1:0] pc;
        logic [DATA_W_DEF-1:0] addr;
    } xcpt_rec_t;

    typedef enum logic {
        XC_IDLE = 1'b0,
        XC_HELD = 1'b1
    } xcpt_state_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, bit 0 never set.
// Priority per bit: flush clears, then issue sets, then writeback clears.
module reg_scoreboard
    import regfile_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    localparam int ADDR_W  = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                issue_en,
    input  logic [ADDR_W-1:0]   issue_addr,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic                flush,
    output logic [NUM_REGS-1:0] pending
);

    logic [NUM_REGS-1:1] r_pending;

    genvar gi;
    generate
        for (gi = 1; gi < NUM_REGS; gi++) begin : g_bit
            logic w_set;
            logic w_clr;
            assign w_set = issue_en && (issue_addr == ADDR_W'(gi));
            assign w_clr = wr_en && (wr_addr == ADDR_W'(gi));

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_pending[gi] <= 1'b0;
                end else if (flush) begin
                    r_pending[gi] <= 1'b0;
                end else if (w_set) begin
                    r_pending[gi] <= 1'b1;
                end else if (w_clr) begin
                    r_pending[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    assign pending = {r_pending, 1'b0};

endmodule

// File: rtl/reg_file_xcpt.sv
// Decode-stage integer register file with RAW scoreboard and exception capture.
// Define REGFILE_BYPASS_EN to forward a same-cycle writeback to the read ports.
module reg_file_xcpt
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int NUM_RD   = 2,
    localparam int ADDR_W  = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_pending,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     issue_en,
    input  logic [ADDR_W-1:0]        issue_addr,
    input  logic                     flush,
    input  logic                     xcpt_valid,
    input  logic [DATA_W-1:0]        xcpt_pc,
    input  logic [DATA_W-1:0]        xcpt_addr,
    input  logic                     xcpt_ack,
    output logic [DATA_W-1:0]        rm_pc,
    output logic [DATA_W-1:0]        rm_addr,
    output logic                     rm_valid,
    output logic                     xcpt_lost
);

    logic [DATA_W-1:0]   r_regs [NUM_REGS];
    logic [NUM_REGS-1:0] w_pending;
    logic                w_wr_live;

    // Entry 0 is reset and never written, so it reads as zero without a mux.
    assign w_wr_live = wr_en && (wr_addr != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_live) begin
            r_regs[wr_addr] <= wr_data;
        end
    end

    reg_scoreboard #(
        .NUM_REGS (NUM_REGS)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .flush      (flush),
        .pending    (w_pending)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [ADDR_W-1:0] w_addr;
            assign w_addr = rd_addr[gi*ADDR_W +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
            logic w_hit;
            assign w_hit = w_wr_live && (wr_addr == w_addr);
            // A writeback retires the producer unless a new one issues to the same index.
            assign rd_data[gi*DATA_W +: DATA_W] = w_hit ? wr_data : r_regs[w_addr];
            assign rd_pending[gi] = w_hit ? (issue_en && (issue_addr == wr_addr))
                                          : w_pending[w_addr];
`else
            assign rd_data[gi*DATA_W +: DATA_W] = r_regs[w_addr];
            assign rd_pending[gi] = w_pending[w_addr];
`endif
        end
    endgenerate

    xcpt_state_t       r_state;
    logic [DATA_W-1:0] r_pc;
    logic [DATA_W-1:0] r_addr;
    logic              r_valid;
    logic              r_lost;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= XC_IDLE;
            r_pc    <= '0;
            r_addr  <= '0;
            r_valid <= 1'b0;
            r_lost  <= 1'b0;
        end else begin
            case (r_state)
                XC_IDLE: begin
                    if (xcpt_valid) begin
                        r_pc    <= xcpt_pc;
                        r_addr  <= xcpt_addr;
                        r_valid <= 1'b1;
                        r_state <= XC_HELD;
                    end
                end
                XC_HELD: begin
                    if (xcpt_ack) begin
                        r_lost <= 1'b0;
                        if (xcpt_valid) begin
                            r_pc   <= xcpt_pc;
                            r_addr <= xcpt_addr;
                        end else begin
                            r_valid <= 1'b0;
                            r_state <= XC_IDLE;
                        end
                    end else if (xcpt_valid) begin
                        r_lost <= 1'b1;
                    end
                end
                default: begin
                    r_state <= XC_IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign rm_pc     = r_pc;
    assign rm_addr   = r_addr;
    assign rm_valid  = r_valid;
    assign xcpt_lost = r_lost;

endmodule

// File: doc/reg_file_xcpt.md
Name: reg_file_xcpt

Overview:
Parametrised integer register file for the decode stage.
- Provides NUM_RD combinational read ports and one write port; register 0 is hardwired to zero.
- Contains a per-register pending-write scoreboard so decode can detect RAW hazards.
- Contains an exception-capture pair (faulting PC and faulting address) with valid, lost and acknowledge handshakes, feeding the exception/privileged logic.

Parameters:
- DATA_W, 32, width of each register and of the exception PC/address.
- NUM_REGS, 32, number of architectural registers; power of two, minimum 2.
- NUM_RD, 2, number of read ports; range 1..4.
- ADDR_W, $clog2(NUM_REGS), register index width; localparam, not overridable.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- rd_addr  in  NUM_RD*ADDR_W  read indices; port k occupies bits [k*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  read data, packed the same way.
- rd_pending  out  NUM_RD  port k source has an outstanding producer.
- wr_en  in  1  writeback strobe.
- wr_addr  in  ADDR_W  writeback index.
- wr_data  in  DATA_W  writeback data.
- issue_en  in  1  an instruction with a destination register issues.
- issue_addr  in  ADDR_W  its destination index.
- flush  in  1  pipeline flush; clears the scoreboard.
- xcpt_valid  in  1  exception report.
- xcpt_pc  in  DATA_W  PC of the faulting instruction.
- xcpt_addr  in  DATA_W  faulting address.
- xcpt_ack  in  1  handler has consumed the captured exception.
- rm_pc  out  DATA_W  captured PC.
- rm_addr  out  DATA_W  captured address.
- rm_valid  out  1  capture registers hold an unacknowledged exception.
- xcpt_lost  out  1  sticky flag: an exception arrived while rm_valid was 1.

Behaviour:
- Reset (asynchronous, active-high): every register, pending bit, rm_pc, rm_addr, rm_valid and xcpt_lost go to 0 immediately. Reset asserted mid-operation discards all in-flight state; the first edge after deassertion behaves like a normal cycle.

Write path:
- On a rising edge with wr_en=1 and wr_addr!=0, reg[wr_addr] <= wr_data.
- A write to index 0 is dropped; reading register 0 always returns 0.

Read path:
- Combinational, zero latency. rd_data[k] = reg[rd_addr[k]].
- With the bypass feature enabled, read data and pending status are overridden by a same-cycle write (see Optional Feature).

Scoreboard (one pending bit per register; index 0 is never pending):
- issue_en=1 with issue_addr!=0 sets pending[issue_addr].
- wr_en=1 clears pending[wr_addr].
- issue and write to the same index in one cycle: set wins (a new producer supersedes).
- flush=1 clears all bits; flush overrides a same-cycle issue.
- rd_pending[k] = pending[rd_addr[k]].

Exception capture, two states:
- IDLE (rm_valid=0):
  - On xcpt_valid: rm_pc <= xcpt_pc, rm_addr <= xcpt_addr, go to HELD.
- HELD (rm_valid=1):
  - xcpt_valid without xcpt_ack: captured values are kept and xcpt_lost <= 1.
  - xcpt_ack without xcpt_valid: return to IDLE and clear xcpt_lost; rm_pc and rm_addr keep their values.
  - xcpt_ack and xcpt_valid in the same cycle: capture the new values, stay in HELD, clear xcpt_lost.
- xcpt_ack in IDLE is ignored.
- Register writes and exception capture are independent and may both take effect in the same cycle.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined: a same-cycle write is forwarded to the readers. If wr_en=1, wr_addr!=0 and wr_addr==rd_addr[k]:
  - rd_data[k] = wr_data.
  - rd_pending[k] = 0, unless issue_en=1 with issue_addr==wr_addr in that cycle, in which case it stays 1.
- Undefined: rd_data and rd_pending reflect stored state only; a same-cycle write becomes visible the next cycle.

Decomposition:
- regfile_pkg holds:
  - constants DATA_W_DEF=32 and NUM_REGS_DEF=32;
  - typedef reg_idx_t (ADDR_W bits);
  - typedef xcpt_rec_t {pc, addr}.
- One natural sub-module, reg_scoreboard, containing the pending bits with their set/clear/flush priority logic.
- Storage and exception capture stay in the top module.

Test Plan:
- Reset: assert rst while not aligned to clk -> all rd_data=0, rd_pending=0, rm_valid=0, xcpt_lost=0 immediately.
- Write then read: write 0xDEADBEEF to r5, read it on port 1 next cycle -> 0xDEADBEEF. Write 0x1234 to r0 -> reading r0 returns 0.
- Bypass (REGFILE_BYPASS_EN defined): wr r7=0xA5A5A5A5 while rd_addr[0]=7 -> rd_data[0]=0xA5A5A5A5 in the same cycle. Same stimulus with the macro undefined -> old value this cycle, new value next cycle.
- Scoreboard: issue r3 -> rd_pending=1 on r3. Issue r3 and write r3 in one cycle -> still pending. Write r3 alone -> cleared. Issue r4 together with flush -> r4 not pending.
- Exceptions: xcpt pc=0x100 addr=0x2000 -> rm_valid=1, rm_pc=0x100. Second xcpt pc=0x200 -> rm_pc stays 0x100, xcpt_lost=1. Ack together with a xcpt pc=0x300 -> rm_pc=0x300, rm_valid=1, xcpt_lost=0.
- Parameters NUM_RD=4, NUM_REGS=16: all four ports read distinct registers r1..r4 correctly in one cycle.
